// File: rtl/debounce_pkg.sv
// Shared state encoding for the switch debouncer FSM.
package debounce_pkg;

    // Bit 1 of the encoding equals the debounced level y in every state.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

endpackage : debounce_pkg

// File: rtl/switch_debouncer_if.sv
// Raw switch input plus the conditioned level and edge outputs.
interface switch_debouncer_if;

    logic a;     // raw asynchronous switch level
    logic y;     // debounced level
    logic rise;  // one-cycle pulse on y 0->1
    logic fall;  // one-cycle pulse on y 1->0
    logic busy;  // a candidate change is being qualified

    // Switch side: drives the raw pin, observes the clean outputs.
    modport master (output a, input y, rise, fall, busy);
    // Debouncer side.
    modport slave  (input a, output y, rise, fall, busy);

endinterface : switch_debouncer_if

// File: rtl/sync_ff.sv
// N-flop synchronizer for one asynchronous bit, synchronous reset to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    // Shift the raw bit through the chain; only the last flop is used.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every stage capture the value
        // its predecessor held before this edge, which is what forms the chain.
        if (rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule : sync_ff

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronizer, stability counter and 4-state FSM producing
// a clean level plus single-cycle rise/fall pulses.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    switch_debouncer_if.slave   bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES);

    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.a),
        .q_o (s)
    );

    // State, counter and registered outputs; reset discards any qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: a change of s must persist STABLE_CYCLES samples.
    always_comb begin
        // NOTE: every output of this block gets a value up front so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d = IDLE_LOW;
        cnt_d   = '0;
        y_d     = 1'b0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = IDLE_HIGH;
                        y_d     = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;          // glitch rejected
                end else if (cnt_q + CNT_ONE == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    y_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    state_d = WAIT_HIGH;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                y_d     = 1'b1;
                state_d = IDLE_HIGH;
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = IDLE_LOW;
                        y_d     = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LOW: begin
                y_d = 1'b1;
                if (s) begin
                    state_d = IDLE_HIGH;         // glitch rejected
                end else if (cnt_q + CNT_ONE == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    y_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    state_d = WAIT_LOW;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
            end
        endcase
    end

    assign bus.y    = y_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: a default build (STABLE_CYCLES=4) and
// a STABLE_CYCLES=1 build run side by side on the same stimulus.
module tb_switch_debouncer;

    localparam int SYNC = 2;
    localparam int ST0  = 4;
    localparam int ST1  = 1;
    localparam int MAXC = 4096;

    typedef struct packed {
        logic y;
        logic rise;
        logic fall;
        logic busy;
    } resp_t;

    typedef struct packed {
        resp_t d0;
        resp_t d1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    switch_debouncer_if bus0 ();
    switch_debouncer_if bus1 ();

    switch_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(ST0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    switch_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(ST1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   k        = 0;   // index of the next rising edge
    int   mon_edge = 0;
    int   last_rst = 0;   // edge index of the most recent reset edge
    bit   a_hist [MAXC];
    bit   y_m    [2];
    exp_t exp_q  [$];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, mon_edge, act, exp);
        end
    endtask

    // Synchronized value the FSM evaluates at edge j: the raw level SYNC edges
    // earlier, or 0 while the synchronizer is still refilling after a reset.
    function automatic bit s_at(input int j);
        if (j - SYNC <= last_rst) return 1'b0;
        return a_hist[j - SYNC];
    endfunction

    // Expected response after edge k for one build: y flips once the last
    // `st` synchronized samples since reset all differ from it; busy means the
    // newest sample disagrees with the (possibly new) y.
    function automatic resp_t predict(input int idx, input int st);
        resp_t r;
        bit flip;
        flip = (k - last_rst >= st);
        for (int j = k - st + 1; j <= k; j++) begin
            if (flip && s_at(j) == y_m[idx]) flip = 1'b0;
        end
        if (flip) y_m[idx] = ~y_m[idx];
        r.y    = y_m[idx];
        r.rise = flip && y_m[idx];
        r.fall = flip && !y_m[idx];
        r.busy = (s_at(k) != y_m[idx]);
        return r;
    endfunction

    // Apply one cycle of stimulus and queue the response expected after the edge.
    task automatic step(input bit r, input bit av);
        exp_t e;
        rst    = r;
        bus0.a = av;
        bus1.a = av;
        a_hist[k] = av;
        if (r) begin
            last_rst = k;
            y_m[0]   = 1'b0;
            y_m[1]   = 1'b0;
            e        = '0;
        end else begin
            e.d0 = predict(0, ST0);
            e.d1 = predict(1, ST1);
        end
        exp_q.push_back(e);
        k++;
        @(negedge clk);
    endtask

    task automatic hold(input bit av, input int n);
        for (int i = 0; i < n; i++) step(1'b0, av);
    endtask

    // Monitor: compare every build output one time unit after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty at edge %0d: got no expectation, required one", mon_edge);
            end else begin
                e = exp_q.pop_front();
                check("y_st4",    bus0.y,    e.d0.y);
                check("rise_st4", bus0.rise, e.d0.rise);
                check("fall_st4", bus0.fall, e.d0.fall);
                check("busy_st4", bus0.busy, e.d0.busy);
                check("y_st1",    bus1.y,    e.d1.y);
                check("rise_st1", bus1.rise, e.d1.rise);
                check("fall_st1", bus1.fall, e.d1.fall);
                check("busy_st1", bus1.busy, e.d1.busy);
            end
            mon_edge++;
        end
    end

    // Stimulus: directed scenarios first, then random run-length bouncing.
    initial begin
        bit v;
        int run;
        bus0.a = 1'b0;
        bus1.a = 1'b0;

        step(1'b1, 1'b1);                       // reset with a=1
        step(1'b1, 1'b1);
        hold(1'b0, 8);
        hold(1'b1, 12);                         // clean rise
        hold(1'b0, 12);                         // clean fall
        hold(1'b1, 3);                          // short pulse, rejected at ST=4
        hold(1'b0, 10);
        hold(1'b1, 1); hold(1'b0, 1);           // bounce 1,0,1,0,1 then held
        hold(1'b1, 1); hold(1'b0, 1);
        hold(1'b1, 12);
        hold(1'b0, 12);
        hold(1'b1, 5);                          // qualification reaches count=3
        step(1'b1, 1'b1);                       // reset mid-qualification
        hold(1'b1, 12);                         // qualifies afresh
        hold(1'b0, 12);

        v = 1'b1;
        for (int c = 0; c < 150; c++) begin
            run = $urandom_range(1, 8);
            for (int i = 0; i < run; i++) begin
                step(($urandom_range(0, 59) == 0), v);
            end
            v = ~v;
        end
        hold(1'b0, 10);

        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_switch_debouncer
